// File: rtl/display_driver_scan_controller.sv
// Row/bit-plane scan controller for a multiplexed LED panel: overlaps the next row load with the current binary-weighted on-time.
// Optional DISPLAY_SCAN_DEADTIME_EN adds deadtime blank cycles and a post-latch dark gap.
module display_driver_scan_controller #(
  parameter int unsigned rows        = 16,
  parameter int unsigned bit_depth   = 4,
  parameter int unsigned base_cycles = 8,
  parameter int unsigned deadtime    = 2,
  localparam int unsigned RW = (rows > 1) ? $clog2(rows) : 1,
  localparam int unsigned PW = (bit_depth > 1) ? $clog2(bit_depth) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          load,
  input  logic          complete,
  output logic [RW-1:0] load_row,
  output logic [PW-1:0] load_plane,
  output logic [RW-1:0] row,
  output logic [PW-1:0] plane,
  output logic          lat,
  output logic          oe_n,
  output logic          frame_start
);

  localparam int unsigned TMAX = base_cycles << (bit_depth - 1);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, BLANK, LATCH} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] row_q, row_d, load_row_q, load_row_d;
  logic [PW-1:0] plane_q, plane_d, load_plane_q, load_plane_d;
  logic          load_q, load_d, lat_q, lat_d, oe_n_q, oe_n_d, fs_q, fs_d;
  logic [TW-1:0] on_time;

`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam int unsigned GW = (deadtime > 0) ? $clog2(deadtime + 1) : 1;
  logic [GW-1:0] gap_q, gap_d, blank_q, blank_d;
  logic [TW-1:0] pend_q, pend_d;
  logic          dark_done;
  assign dark_done = (timer_q == '0) && (gap_q == '0);
`else
  logic          dark_done;
  assign dark_done = (timer_q == '0);
`endif

  assign on_time = TW'(base_cycles) << plane_q;

  // Next-state, counters and registered-output values
  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    row_d        = row_q;
    plane_d      = plane_q;
    load_row_d   = load_row_q;
    load_plane_d = load_plane_q;
`ifdef DISPLAY_SCAN_DEADTIME_EN
    gap_d   = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    pend_d  = pend_q;
    blank_d = blank_q;
    if (gap_q == GW'(1)) timer_d = pend_q;
`endif
    case (state_q)
      IDLE: if (enable) state_d = LOAD;
      LOAD: if (complete) state_d = WAIT;
      WAIT: if (dark_done) state_d = BLANK;
      BLANK: begin
`ifdef DISPLAY_SCAN_DEADTIME_EN
        if (blank_q == GW'(deadtime)) begin
          blank_d = '0;
          state_d = LATCH;
          row_d   = load_row_q;
          plane_d = load_plane_q;
        end else begin
          blank_d = blank_q + GW'(1);
        end
`else
        state_d = LATCH;
        row_d   = load_row_q;
        plane_d = load_plane_q;
`endif
      end
      LATCH: begin
`ifdef DISPLAY_SCAN_DEADTIME_EN
        if (deadtime == 0) begin
          timer_d = on_time;
        end else begin
          gap_d  = GW'(deadtime);
          pend_d = on_time;
        end
`else
        timer_d = on_time;
`endif
        if (load_plane_q == PW'(bit_depth - 1)) begin
          load_plane_d = '0;
          load_row_d   = (load_row_q == RW'(rows - 1)) ? '0 : load_row_q + RW'(1);
        end else begin
          load_plane_d = load_plane_q + PW'(1);
        end
        state_d = enable ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_d = (state_d == LOAD);
    lat_d  = (state_d == LATCH);
    fs_d   = (state_d == LATCH) && (row_d == '0) && (plane_d == '0);
    oe_n_d = (timer_d == '0) || (state_d == BLANK) || (state_d == LATCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      load_row_q   <= '0;
      load_plane_q <= '0;
      load_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      load_row_q   <= load_row_d;
      load_plane_q <= load_plane_d;
      load_q       <= load_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      fs_q         <= fs_d;
    end
  end

`ifdef DISPLAY_SCAN_DEADTIME_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q   <= '0;
      pend_q  <= '0;
      blank_q <= '0;
    end else begin
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
    end
  end
`endif

  assign load        = load_q;
  assign lat         = lat_q;
  assign oe_n        = oe_n_q;
  assign frame_start = fs_q;
  assign row         = row_q;
  assign plane       = plane_q;
  assign load_row    = load_row_q;
  assign load_plane  = load_plane_q;

endmodule

// File: tb/tb_display_driver_scan_controller.sv
// Scoreboard bench for display_driver_scan_controller: loader stub pushes expected latches, monitor checks lat/oe_n.
module tb_display_driver_scan_controller;
  localparam int unsigned ROWS = 4, BD = 2, BASE = 8, DT_P = 2;
`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam int GAP = DT_P;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, complete = 1'b0;
  logic       load, lat, oe_n, frame_start;
  logic [1:0] load_row, row;
  logic [0:0] load_plane, plane;

  display_driver_scan_controller #(.rows(ROWS), .bit_depth(BD), .base_cycles(BASE), .deadtime(DT_P)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .complete(complete),
    .load_row(load_row), .load_plane(load_plane), .row(row), .plane(plane),
    .lat(lat), .oe_n(oe_n), .frame_start(frame_start));

  always #5 clk = ~clk;

  typedef struct {int r; int p; int fs;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, n_lat = 0;
  int stub_n = 5, stub_cnt = 0, k = 0;
  int lit_wait = 0, lit_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Loader stub: completes on the stub_n-th load cycle; the k-th load is row (k/BD)%ROWS, plane k%BD
  always @(negedge clk) begin
    if (rst) begin
      stub_cnt = 0; complete = 1'b0; k = 0;
    end else begin
      complete = 1'b0;
      if (load) begin
        stub_cnt++;
        if (stub_cnt >= stub_n) begin
          exp_t e;
          e.r = (k / BD) % ROWS;
          e.p = k % BD;
          e.fs = (k % (ROWS * BD) == 0) ? 1 : 0;
          check("load_row", int'(load_row), e.r);
          check("load_plane", int'(load_plane), e.p);
          sb.push_back(e);
          k++;
          complete = 1'b1;
        end
      end else begin
        stub_cnt = 0;
      end
    end
  end

  // Monitor: pops an expectation on each lat, then tracks the expected lit window
  always @(negedge clk) begin
    if (rst) begin
      sb.delete(); lit_wait = 0; lit_cnt = 0;
    end else if (lat) begin
      n_lat++;
      if (sb.size() == 0) begin
        check("lat_without_complete", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("row", int'(row), e.r);
        check("plane", int'(plane), e.p);
        check("frame_start", int'(frame_start), e.fs);
        lit_wait = GAP;
        lit_cnt = BASE << e.p;
      end
      check("oe_n_at_lat", int'(oe_n), 1);
    end else begin
      int exp_oe;
      if (lit_wait > 0) begin exp_oe = 1; lit_wait--; end
      else if (lit_cnt > 0) begin exp_oe = 0; lit_cnt--; end
      else exp_oe = 1;
      check("oe_n", int'(oe_n), exp_oe);
      check("frame_start_idle", int'(frame_start), 0);
    end
  end

  task automatic wait_latches(input int n, input int cap);
    int target;
    target = n_lat + n;
    for (int c = 0; c < cap; c++) begin
      @(negedge clk);
      if (n_lat >= target) return;
    end
    check("latch_timeout", n_lat, target);
  endtask

  initial begin
    int c;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_load", int'(load), 0);
    check("rst_lat", int'(lat), 0);
    check("rst_oe_n", int'(oe_n), 1);
    check("rst_row", int'(row), 0);
    check("rst_plane", int'(plane), 0);
    check("rst_frame_start", int'(frame_start), 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 enable = 1'b1;
    c = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) check("load_first_cycle", int'(load), 1);
      if (lat) begin c = i; seen = 1; end
    end
    check("first_lat_cycle", c, 8 + GAP);

    wait_latches(40, 4000);
    stub_n = 30;
    wait_latches(6, 2000);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      enable = ($urandom % 8) != 0;
      stub_n = $urandom_range(1, 25);
    end
    #1 enable = 1'b1;
    stub_n = 5;

    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (load && !oe_n) seen = 1;
    end
    check("found_load_during_on", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_load", int'(load), 0);
    check("midrst_oe_n", int'(oe_n), 1);
    check("midrst_lat", int'(lat), 0);
    check("midrst_load_row", int'(load_row), 0);
    check("midrst_load_plane", int'(load_plane), 0);
    check("midrst_row", int'(row), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_latches(20, 3000);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #2;
      enable = ($urandom % 6) != 0;
      stub_n = $urandom_range(1, 30);
    end
    #1 enable = 1'b0;
    repeat (80) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/display_driver_scan_controller.md
DISPLAY_DRIVER_SCAN_CONTROLLER -- requirements
Module: display_driver_scan_controller

Interface
REQ-001 Parameter rows, default 16: scan rows; row output width $clog2(rows), minimum 1.
REQ-002 Parameter bit_depth, default 4: bit planes per row; plane output width $clog2(bit_depth), minimum 1.
REQ-003 Parameter base_cycles, default 8: on-time of plane 0 in clk cycles; plane b on-time is base_cycles << b.
REQ-004 Parameter deadtime, default 2: extra blank cycles, used only under the configuration macro.
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port enable  input  1  run request.
REQ-008 Port load  output  1  level request to the row loader.
REQ-009 Port complete  input  1  one-cycle done pulse from the row loader.
REQ-010 Port load_row / load_plane  output  row/plane widths  row and plane currently being loaded.
REQ-011 Port row / plane  output  row/plane widths  row address and plane currently displayed.
REQ-012 Port lat  output  1  one-cycle latch pulse to the panel.
REQ-013 Port oe_n  output  1  active-low panel output enable.
REQ-014 Port frame_start  output  1  one-cycle pulse, first row of a frame latched.

Function
REQ-015 The FSM SHALL use states IDLE, LOAD, WAIT, BLANK, LATCH.
REQ-016 IDLE: when enable=1, go to LOAD next cycle; otherwise stay.
REQ-017 LOAD: hold load=1; on sampling complete=1, go to WAIT with load=0 the next cycle; complete is ignored in all other states.
REQ-018 WAIT: stay while the on-time timer is nonzero; when it is zero, go to BLANK.
REQ-019 BLANK: exactly 1 cycle (1+deadtime with macro); on exit, row<=load_row and plane<=load_plane.
REQ-020 LATCH: lat=1 for exactly 1 cycle; frame_start=1 in the same cycle iff row=0 and plane=0.
REQ-021 On LATCH exit: timer<=base_cycles<<plane; load_plane increments, wrapping bit_depth-1->0; load_row increments on plane wrap, wrapping rows-1->0.
REQ-022 On LATCH exit, the next state SHALL be LOAD if enable=1, else IDLE; enable is sampled only here and in IDLE.
REQ-023 The timer SHALL decrement by 1 per cycle while nonzero, in every state including IDLE.
REQ-024 oe_n=0 iff timer!=0, so the display is lit exactly base_cycles<<plane cycles starting the cycle after lat.
REQ-025 The next load SHALL overlap the current on-time; if loading exceeds the on-time, oe_n remains 1 until the next LATCH.
REQ-026 The timer width SHALL hold base_cycles<<(bit_depth-1) without overflow.
REQ-027 oe_n SHALL be 1 during BLANK and LATCH.

Reset
REQ-028 While rst=1, outputs SHALL be: state IDLE, load=0, lat=0, oe_n=1, frame_start=0, row=plane=load_row=load_plane=0, timer=0; this SHALL take effect immediately, including mid-LOAD or mid-on-time.
REQ-029 After rst falls, the first load SHALL be row 0, plane 0.

Configuration
REQ-030 Macro DISPLAY_SCAN_DEADTIME_EN defined: BLANK lasts 1+deadtime cycles, and oe_n is held 1 for deadtime cycles after LATCH before the timer starts.
REQ-031 Macro DISPLAY_SCAN_DEADTIME_EN undefined: BLANK is 1 cycle; the deadtime parameter is unused and the post-LATCH gap is absent.

Verification
Bench configuration for REQ-032 to REQ-036: rows=4, bit_depth=2, base_cycles=8; loader stub pulses complete on the 5th cycle of load unless stated otherwise.
REQ-032 Reset, then hold rst=1 -> load=0, lat=0, oe_n=1, row=0, plane=0, frame_start=0.
REQ-033 enable=1 at cycle 0 -> load high cycles 1-5, BLANK at 7, lat and frame_start at 8, oe_n low cycles 9-16 with row=0 plane=0, and the second load starting at 9.
REQ-034 Run continuously -> alternating oe_n low lengths of 8 and 16 cycles; row sequence 0,0,1,1,2,2,3,3,0; frame_start once every 8 latches.
REQ-035 Stub complete delayed to 30 cycles -> oe_n returns high after the 8-cycle on-time and stays high until the next lat; no lat without a preceding complete.
REQ-036 Assert rst during LOAD with timer=5 -> the same cycle gives load=0 and oe_n=1; after release, load_row=0 and load_plane=0.
REQ-037 DISPLAY_SCAN_DEADTIME_EN with deadtime=2 -> BLANK lasts 3 cycles, and oe_n stays high 2 cycles after lat before 8 low cycles.
